// File: rtl/config_memory_unit_if.sv
// Signal bundle between the control unit / consumers and the configuration memory.
// The master drives write and read requests; the slave returns registered results.
interface config_memory_unit_if;
  logic        write_en;
  logic [34:0] configin;
  logic        rd_req;
  logic [1:0]  rd_addr;
  logic        rd_valid;
  logic [34:0] rd_data;
  logic [34:0] config_active;
  logic [3:0]  slot_valid;
  logic [1:0]  syskey;
  logic [7:0]  wr_count;
  logic [1:0]  dbg_state;

  modport master (
    output write_en, configin, rd_req, rd_addr,
    input  rd_valid, rd_data, config_active, slot_valid, syskey, wr_count, dbg_state
  );

  modport slave (
    input  write_en, configin, rd_req, rd_addr,
    output rd_valid, rd_data, config_active, slot_valid, syskey, wr_count, dbg_state
  );
endinterface

// File: rtl/config_memory_unit.sv
// 4-entry circular config bank that commits once per write_en episode and rotates syskey on each commit.
// Commit and read both take effect at the next edge; requests are never stalled (no backpressure).
module config_memory_unit #(
  parameter logic [1:0] KEY_INIT = 2'b10,
  parameter int         DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 arst_n,
  config_memory_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b01,
    S_HOLD = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic               commit;

  logic [34:0]        bank_q [DEPTH];
  logic [DEPTH-1:0]   slot_valid_q;
  logic [34:0]        config_active_q;
  logic [1:0]         wr_ptr_q;
  logic [1:0]         syskey_q;
  logic [7:0]         wr_count_q;
  logic [34:0]        rd_data_q;
  logic               rd_valid_q;

  // Illegal state encodings fall back to idle without committing.
  always_comb begin
    state_d = S_IDLE;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.write_en) begin
          commit  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD:  state_d = bus.write_en ? S_HOLD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
      slot_valid_q    <= '0;
      config_active_q <= '0;
      wr_ptr_q        <= '0;
      syskey_q        <= KEY_INIT;
      wr_count_q      <= '0;
    end else if (commit) begin
      bank_q[wr_ptr_q]       <= bus.configin;
      slot_valid_q[wr_ptr_q] <= 1'b1;
      config_active_q        <= bus.configin;
      wr_ptr_q               <= wr_ptr_q + 2'd1;
      syskey_q               <= syskey_q + 2'd1;
      if (wr_count_q != 8'hFF) wr_count_q <= wr_count_q + 8'd1;
    end
  end

  // Reads sample the bank before this edge's commit lands, so a same-slot
  // collision returns the old contents.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) rd_data_q <= bank_q[bus.rd_addr];
    end
  end

  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.config_active = config_active_q;
  assign bus.slot_valid    = slot_valid_q;
  assign bus.syskey        = syskey_q;
  assign bus.wr_count      = wr_count_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_config_memory_unit.sv
// Randomized and directed bench for config_memory_unit against an episode-level reference model.
module tb_config_memory_unit;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  config_memory_unit_if bus();

  config_memory_unit #(.KEY_INIT(2'b10), .DEPTH(4)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a commit happens when write_en is high and the previous
  // sampled write_en was low (or reset intervened).
  logic [34:0] m_bank [4];
  logic [3:0]  m_valid;
  logic [34:0] m_active;
  logic [34:0] m_rd_data;
  logic        m_rd_valid;
  int          m_ptr, m_key, m_cnt;
  bit          m_armed;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_bank[i] = '0;
    m_valid = '0; m_active = '0; m_rd_data = '0; m_rd_valid = 1'b0;
    m_ptr = 0; m_key = 2; m_cnt = 0; m_armed = 1'b1;
  endtask

  // Drive inputs, take one clock edge, advance the model, settle 1 time unit.
  task automatic step(input bit we, input logic [34:0] cfg, input bit rr, input logic [1:0] ra);
    bus.write_en = we; bus.configin = cfg; bus.rd_req = rr; bus.rd_addr = ra;
    @(posedge clk);
    if (rr) begin m_rd_data = m_bank[ra]; m_rd_valid = 1'b1; end
    else m_rd_valid = 1'b0;
    if (we && m_armed) begin
      m_bank[m_ptr] = cfg; m_valid[m_ptr] = 1'b1; m_active = cfg;
      m_ptr = (m_ptr + 1) % 4; m_key = (m_key + 1) % 4;
      if (m_cnt < 255) m_cnt++;
    end
    m_armed = !we;
    #1;
  endtask

  task automatic idle_inputs();
    bus.write_en = 1'b0; bus.configin = '0; bus.rd_req = 1'b0; bus.rd_addr = '0;
  endtask

  // Asserts reset away from the clock edge and releases it mid-cycle.
  task automatic do_reset();
    #2 arst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #3 arst_n = 1'b1;
  endtask

  task automatic commit_one(input logic [34:0] v);
    step(1'b1, v, 1'b0, 2'd0);
    step(1'b0, '0, 1'b0, 2'd0);
  endtask

  task automatic test_reset();
    idle_inputs();
    step(1'b1, 35'h7, 1'b1, 2'd0);
    #2 arst_n = 1'b0;
    model_reset();
    #1;
    n_vec++; if (bus.syskey !== 2'b10) begin n_err++; $display("FAIL reset_key got %b exp 10", bus.syskey); end
    n_vec++; if (bus.wr_count !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", bus.wr_count); end
    n_vec++; if (bus.slot_valid !== 4'b0) begin n_err++; $display("FAIL reset_slot got %b exp 0000", bus.slot_valid); end
    n_vec++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rdv got %b exp 0", bus.rd_valid); end
    n_vec++; if (bus.config_active !== 35'h0) begin n_err++; $display("FAIL reset_active got %h exp 0", bus.config_active); end
    n_vec++; if (bus.dbg_state !== 2'b01) begin n_err++; $display("FAIL reset_state got %b exp 01", bus.dbg_state); end
    @(posedge clk);
    #3 arst_n = 1'b1;
  endtask

  task automatic test_long_write();
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 35'h1_2345_6789, 1'b0, 2'd0);
    step(1'b0, '0, 1'b1, 2'd0);
    n_vec++; if (bus.wr_count !== 8'd1) begin n_err++; $display("FAIL long_cnt got %0d exp 1", bus.wr_count); end
    n_vec++; if (bus.slot_valid !== 4'b0001) begin n_err++; $display("FAIL long_slot got %b exp 0001", bus.slot_valid); end
    n_vec++; if (bus.syskey !== 2'b11) begin n_err++; $display("FAIL long_key got %b exp 11", bus.syskey); end
    n_vec++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 35'h1_2345_6789)
      begin n_err++; $display("FAIL long_read got v=%b %h exp v=1 123456789", bus.rd_valid, bus.rd_data); end
  endtask

  task automatic test_wrap();
    logic [34:0] exp_rd [4];
    exp_rd[0] = 35'd5; exp_rd[1] = 35'd2; exp_rd[2] = 35'd3; exp_rd[3] = 35'd4;
    do_reset();
    for (int v = 1; v <= 5; v++) commit_one(35'(v));
    for (int s = 0; s < 4; s++) begin
      step(1'b0, '0, 1'b1, 2'(s));
      n_vec++; if (bus.rd_data !== exp_rd[s] || bus.rd_data !== m_rd_data)
        begin n_err++; $display("FAIL wrap_read%0d got %h exp %h", s, bus.rd_data, exp_rd[s]); end
    end
    n_vec++; if (bus.syskey !== 2'b11) begin n_err++; $display("FAIL wrap_key got %b exp 11", bus.syskey); end
    n_vec++; if (bus.wr_count !== 8'd5) begin n_err++; $display("FAIL wrap_cnt got %0d exp 5", bus.wr_count); end
    n_vec++; if (bus.config_active !== 35'd5) begin n_err++; $display("FAIL wrap_active got %h exp 5", bus.config_active); end
    n_vec++; if (bus.slot_valid !== 4'b1111) begin n_err++; $display("FAIL wrap_slot got %b exp 1111", bus.slot_valid); end
  endtask

  task automatic test_collision();
    do_reset();
    commit_one(35'h10); commit_one(35'hA); commit_one(35'h20); commit_one(35'h30); commit_one(35'h40);
    step(1'b1, 35'hB, 1'b1, 2'd1);
    n_vec++; if (bus.rd_data !== 35'hA) begin n_err++; $display("FAIL coll_old got %h exp a", bus.rd_data); end
    step(1'b0, '0, 1'b1, 2'd1);
    n_vec++; if (bus.rd_data !== 35'hB) begin n_err++; $display("FAIL coll_new got %h exp b", bus.rd_data); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) commit_one(35'(i));
    n_vec++; if (bus.wr_count !== 8'd255) begin n_err++; $display("FAIL sat_cnt got %0d exp 255", bus.wr_count); end
    n_vec++; if (bus.syskey !== 2'b10) begin n_err++; $display("FAIL sat_key got %b exp 10", bus.syskey); end
    n_vec++; if (bus.config_active !== 35'd259) begin n_err++; $display("FAIL sat_active got %h exp 103", bus.config_active); end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    step(1'b1, 35'h55, 1'b0, 2'd0);
    step(1'b1, 35'h55, 1'b0, 2'd0);
    n_vec++; if (bus.dbg_state !== 2'b10) begin n_err++; $display("FAIL hold_state got %b exp 10", bus.dbg_state); end
    #2 arst_n = 1'b0;
    model_reset();
    #1;
    n_vec++; if (bus.wr_count !== 8'd0 || bus.dbg_state !== 2'b01)
      begin n_err++; $display("FAIL hold_rst got cnt=%0d st=%b exp 0 01", bus.wr_count, bus.dbg_state); end
    @(posedge clk);
    #3 arst_n = 1'b1;
    n_vec++; if (bus.wr_count !== 8'd0) begin n_err++; $display("FAIL hold_release got %0d exp 0", bus.wr_count); end
    step(1'b1, 35'h66, 1'b0, 2'd0);
    n_vec++; if (bus.wr_count !== 8'd1 || bus.config_active !== 35'h66)
      begin n_err++; $display("FAIL hold_recommit got cnt=%0d act=%h exp 1 66", bus.wr_count, bus.config_active); end
    step(1'b1, 35'h77, 1'b0, 2'd0);
    n_vec++; if (bus.wr_count !== 8'd1) begin n_err++; $display("FAIL hold_once got %0d exp 1", bus.wr_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int v = 0; v < 4; v++) commit_one({3'b101, $urandom()});
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1, 2'(i));
      n_vec++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== m_bank[i % 4])
        begin n_err++; $display("FAIL b2b_read%0d got v=%b %h exp v=1 %h", i, bus.rd_valid, bus.rd_data, m_bank[i % 4]); end
    end
    step(1'b0, '0, 1'b0, 2'd0);
    n_vec++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== m_bank[3])
      begin n_err++; $display("FAIL b2b_hold got v=%b %h exp v=0 %h", bus.rd_valid, bus.rd_data, m_bank[3]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) != 0), {3'($urandom()), 32'($urandom())},
           1'($urandom()), 2'($urandom()));
      n_vec++; if (bus.rd_valid !== m_rd_valid) begin n_err++; $display("FAIL rnd_rdv c%0d got %b exp %b", i, bus.rd_valid, m_rd_valid); end
      n_vec++; if (bus.rd_data !== m_rd_data) begin n_err++; $display("FAIL rnd_rdd c%0d got %h exp %h", i, bus.rd_data, m_rd_data); end
      n_vec++; if (bus.config_active !== m_active) begin n_err++; $display("FAIL rnd_act c%0d got %h exp %h", i, bus.config_active, m_active); end
      n_vec++; if (bus.slot_valid !== m_valid) begin n_err++; $display("FAIL rnd_slot c%0d got %b exp %b", i, bus.slot_valid, m_valid); end
      n_vec++; if (bus.syskey !== 2'(m_key)) begin n_err++; $display("FAIL rnd_key c%0d got %b exp %0d", i, bus.syskey, m_key); end
      n_vec++; if (bus.wr_count !== 8'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt c%0d got %0d exp %0d", i, bus.wr_count, m_cnt); end
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #12 arst_n = 1'b1;
    test_reset();
    test_long_write();
    test_wrap();
    test_collision();
    test_saturation();
    test_reset_mid_hold();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
